// File: rtl/repeat_byte_4_sched.sv
// repeat_byte_4_sched: arbitrates two byte requesters and streams {x+1,x+2,x+3,x+4} MSB-first; define REPEAT_BYTE_4_SCHED_RR_EN for round-robin grant, else fixed priority to requester 0.
module repeat_byte_4_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_tag,
  output logic       busy
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [1:0] idx, idx_nx;
  logic [31:0] word, word_nx;
  logic tag, tag_nx, ptr, gnt_idx, grant_valid, accept, fire;
  logic [7:0] x;
  assign grant_valid = req0_valid | req1_valid;
  assign gnt_idx = ptr ? req1_valid : ~req0_valid;
  assign x = gnt_idx ? req1_data : req0_data;
  assign fire = out_valid & out_ready;
  // rst gating keeps both readys low while reset is held
  assign accept = ~rst & grant_valid & (state == IDLE | (fire & out_last));
  assign req0_ready = accept & ~gnt_idx;
  assign req1_ready = accept & gnt_idx;
  assign out_valid = state == SEND;
  assign busy = state == SEND;
  assign out_data = out_valid ? word[{~idx, 3'b111} -: 8] : 8'd0;
  assign out_last = out_valid & (idx == 2'd3);
  assign out_tag = tag;
`ifdef REPEAT_BYTE_4_SCHED_RR_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= 1'b0;
    else if (accept) ptr <= ~gnt_idx;
`else
  assign ptr = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    word_nx = word;
    tag_nx = tag;
    if (fire) begin
      idx_nx = idx + 2'd1;
      state_nx = out_last ? IDLE : SEND;
    end
    if (accept) begin
      word_nx = {x + 8'd1, x + 8'd2, x + 8'd3, x + 8'd4};
      tag_nx = gnt_idx;
      idx_nx = 2'd0;
      state_nx = SEND;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= 2'd0;
      word <= 32'd0;
      tag <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      word <= word_nx;
      tag <= tag_nx;
    end
endmodule

// File: tb/tb_repeat_byte_4_sched.sv
// tb_repeat_byte_4_sched: directed scenario tasks with hand-computed byte sequences.
module tb_repeat_byte_4_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] req0_data = 8'd0, req1_data = 8'd0;
  logic req0_ready, req1_ready, out_valid, out_last, out_tag, busy;
  logic [7:0] out_data;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  repeat_byte_4_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_tag(out_tag), .busy(busy)
  );
  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req0_data = 8'h10;
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_last, out_tag, busy} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h l=%b t=%b b=%b want all 0", out_valid, out_data, out_last, out_tag, busy);
    end
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_single();
    req0_valid = 1'b1;
    req0_data = 8'h10;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_grant got %b%b want 10", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 + 8'(i) || out_last !== (i == 3) || out_tag !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_byte%0d got v=%b d=%h l=%b t=%b want v=1 d=%h l=%b t=0", i, out_valid, out_data, out_last, out_tag, 8'h11 + 8'(i), i == 3);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got v=%b b=%b want 0 0", out_valid, busy);
    end
  endtask
  task automatic test_wrap();
    logic [7:0] exp [4];
    exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    req1_valid = 1'b1;
    req1_data = 8'hFD;
    out_ready = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 3) || out_tag !== 1'b1) begin
        errors++;
        $display("FAIL wrap_byte%0d got v=%b d=%h l=%b t=%b want v=1 d=%h l=%b t=1", i, out_valid, out_data, out_last, out_tag, exp[i], i == 3);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_idle got v=%b want 0", out_valid);
    end
  endtask
  task automatic test_backpressure();
    req0_valid = 1'b1;
    req0_data = 8'h10;
    out_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data = 8'h77;
    req1_data = 8'h88;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h13 || out_last !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d got v=%b d=%h l=%b r=%b%b want v=1 d=13 l=0 r=00", i, out_valid, out_data, out_last, req0_ready, req1_ready);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_data !== 8'h13) begin
      errors++;
      $display("FAIL stall_release got d=%h want 13", out_data);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h14 || out_last !== 1'b1 || out_tag !== 1'b0) begin
      errors++;
      $display("FAIL stall_last got v=%b d=%h l=%b t=%b want v=1 d=14 l=1 t=0", out_valid, out_data, out_last, out_tag);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle got v=%b want 0", out_valid);
    end
  endtask
  task automatic test_contention();
    logic [2:0] tags;
`ifdef REPEAT_BYTE_4_SCHED_RR_EN
    tags = 3'b010;
`else
    tags = 3'b000;
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data = 8'h20;
    req1_data = 8'h40;
    out_ready = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) begin
        if (w == 2 && i == 3) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b1 || out_tag !== tags[w] || out_data !== (tags[w] ? 8'h41 : 8'h21) + 8'(i) || out_last !== (i == 3)) begin
          errors++;
          $display("FAIL contend_w%0d_b%0d got v=%b t=%b d=%h l=%b want v=1 t=%b d=%h l=%b", w, i, out_valid, out_tag, out_data, out_last, tags[w], (tags[w] ? 8'h41 : 8'h21) + 8'(i), i == 3);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL contend_idle got v=%b want 0", out_valid);
    end
  endtask
  task automatic test_back_to_back();
    req0_valid = 1'b1;
    req0_data = 8'h30;
    out_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    req1_valid = 1'b1;
    req1_data = 8'h50;
    #1;
    checks++;
    if (out_data !== 8'h34 || out_last !== 1'b1 || req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_last got d=%h l=%b r1=%b want d=34 l=1 r1=1", out_data, out_last, req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h51 + 8'(i) || out_tag !== 1'b1 || out_last !== (i == 3)) begin
        errors++;
        $display("FAIL b2b_byte%0d got v=%b d=%h t=%b l=%b want v=1 d=%h t=1 l=%b", i, out_valid, out_data, out_tag, out_last, 8'h51 + 8'(i), i == 3);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset_mid();
    req0_valid = 1'b1;
    req0_data = 8'h60;
    out_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data = 8'h00;
    req1_data = 8'h99;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst got v=%b b=%b r=%b%b want 0 0 00", out_valid, busy, req0_ready, req1_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_grant got %b%b want 10", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h01 + 8'(i) || out_tag !== 1'b0 || out_last !== (i == 3)) begin
        errors++;
        $display("FAIL midrst_byte%0d got v=%b d=%h t=%b l=%b want v=1 d=%h t=0 l=%b", i, out_valid, out_data, out_tag, out_last, 8'h01 + 8'(i), i == 3);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle got v=%b want 0", out_valid);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
